cipher_sequencer: RTL and testbench
===================================

CIPHER_SEQUENCER -- requirements
Module: cipher_sequencer

Interface
REQ-001 SHALL have parameter: WARMUP_CYCLES, default 64, number of discarded keystream steps after load (legal 1..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  begin a job; sampled only in S_IDLE.
REQ-005 SHALL have port: abort  input  1  terminate any job; return to S_IDLE.
REQ-006 SHALL have port: len  input  4  bytes to produce; 0 means 16; latched on accepted start.
REQ-007 SHALL have port: ack  input  1  consumer acknowledge of finished job.
REQ-008 SHALL have port: core_load  output  1  load key/IV into keystream core.
REQ-009 SHALL have port: core_step  output  1  advance keystream core one step.
REQ-010 SHALL have port: out_capture  output  1  output holder latches current XOR'd byte.
REQ-011 SHALL have port: byte_idx  output  4  index of byte being captured.
REQ-012 SHALL have port: output_is_ready  output  1  job complete, data held.
REQ-013 SHALL have port: busy  output  1  high in every state except S_IDLE.

Function
REQ-014 SHALL implement states S_IDLE, S_LOAD, S_WARMUP, S_GEN, S_DONE; all outputs registered-state decoded (Moore).
REQ-015 S_IDLE: start=1 SHALL latch len (0 -> 16) and go to S_LOAD; start outside S_IDLE SHALL be ignored.
REQ-016 S_LOAD SHALL last exactly one cycle with core_load=1, then go to S_WARMUP.
REQ-017 S_WARMUP SHALL assert core_step for exactly WARMUP_CYCLES consecutive cycles (8-bit down-counter), then go to S_GEN.
REQ-018 S_GEN SHALL assert core_step and out_capture every cycle, byte_idx counting 0 up to len-1; after byte len-1 go to S_DONE.
REQ-019 byte_idx SHALL be 0 outside S_GEN; byte count of 16 SHALL end at byte_idx 15 without overflow.
REQ-020 S_DONE SHALL hold output_is_ready=1 until ack=1, then go to S_IDLE next cycle; ack outside S_DONE SHALL be ignored.
REQ-021 abort=1 in any state SHALL force S_IDLE next cycle, clearing counters; abort has priority over start, ack and all counter transitions.
REQ-022 Latency start-to-output_is_ready SHALL be 1 + WARMUP_CYCLES + len_eff + 1 cycles (start edge to first DONE cycle).
REQ-023 core_load, core_step, out_capture SHALL be 0 in S_IDLE and S_DONE.

Reset
REQ-024 nrst=0 SHALL immediately force S_IDLE, counters 0, and all outputs 0, including mid-job.
REQ-025 First rising edge after nrst release SHALL behave as S_IDLE.

Configuration
REQ-026 Macro CIPHER_SEQ_WARMUP_EN defined: S_WARMUP and WARMUP_CYCLES behave per REQ-017.
REQ-027 Macro CIPHER_SEQ_WARMUP_EN undefined: S_WARMUP and its counter SHALL not exist; S_LOAD goes directly to S_GEN; latency = len_eff + 2.

Verification
REQ-028 WARMUP_CYCLES=4, start with len=3 -> core_load 1 cycle, core_step 7 cycles, out_capture 3 cycles byte_idx 0,1,2, output_is_ready after 9 cycles; ack -> busy=0 next cycle.
REQ-029 len=0 -> 16 out_capture pulses, byte_idx 0..15, then output_is_ready.
REQ-030 abort asserted on 2nd S_GEN cycle -> S_IDLE next cycle, all outputs 0, no output_is_ready.
REQ-031 start held high through job and ack delayed 5 cycles -> no restart before S_IDLE; output_is_ready stays 1 for 5 cycles.
REQ-032 nrst pulsed low mid-S_WARMUP -> outputs 0 asynchronously; new start then produces full normal sequence.
REQ-033 Build without CIPHER_SEQ_WARMUP_EN, len=2 -> core_load then 2 capture cycles, output_is_ready 3rd cycle after start edge.

Source files
------------

// File: rtl/cipher_sequencer_if.sv
// cipher_sequencer_if: control/status bundle between a job master and the cipher sequencer.
interface cipher_sequencer_if;
    logic       start;
    logic       abort;
    logic [3:0] len;
    logic       ack;
    logic       core_load;
    logic       core_step;
    logic       out_capture;
    logic [3:0] byte_idx;
    logic       output_is_ready;
    logic       busy;
    modport master (
        output start, abort, len, ack,
        input  core_load, core_step, out_capture, byte_idx, output_is_ready, busy
    );
    modport slave (
        input  start, abort, len, ack,
        output core_load, core_step, out_capture, byte_idx, output_is_ready, busy
    );
endinterface

// File: rtl/cipher_sequencer.sv
// cipher_sequencer: Moore FSM sequencing keystream load, warmup, byte generation and done handshake.
// Warmup phase exists only when CIPHER_SEQ_WARMUP_EN is defined.
module cipher_sequencer #(
    parameter int WARMUP_CYCLES = 64
) (
    input  logic clk,
    input  logic nrst,
    cipher_sequencer_if.slave bus
);
`ifdef CIPHER_SEQ_WARMUP_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WARMUP, S_GEN, S_DONE} state_t;
    logic [7:0] warm_q, warm_d;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GEN, S_DONE} state_t;
`endif
    state_t     state_q, state_d;
    logic [3:0] last_q, last_d;
    logic [3:0] idx_q, idx_d;

    if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_bad_warmup
        $error("WARMUP_CYCLES must be in 1..255");
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            last_q  <= '0;
            idx_q   <= '0;
`ifdef CIPHER_SEQ_WARMUP_EN
            warm_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
`ifdef CIPHER_SEQ_WARMUP_EN
            warm_q  <= warm_d;
`endif
        end
    end

    // last_q holds the final byte index; len=0 wraps to 15, giving 16 bytes
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
`ifdef CIPHER_SEQ_WARMUP_EN
        warm_d  = warm_q;
`endif
        if (bus.abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
`ifdef CIPHER_SEQ_WARMUP_EN
            warm_d  = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    state_d = S_LOAD;
                    last_d  = bus.len - 4'd1;
                end
`ifdef CIPHER_SEQ_WARMUP_EN
                S_LOAD: begin
                    state_d = S_WARMUP;
                    warm_d  = 8'(WARMUP_CYCLES - 1);
                end
                S_WARMUP: if (warm_q == 8'd0) state_d = S_GEN;
                          else warm_d = warm_q - 8'd1;
`else
                S_LOAD: state_d = S_GEN;
`endif
                S_GEN: if (idx_q == last_q) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else idx_d = idx_q + 4'd1;
                S_DONE: if (bus.ack) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.core_load       = state_q == S_LOAD;
`ifdef CIPHER_SEQ_WARMUP_EN
    assign bus.core_step       = state_q == S_WARMUP || state_q == S_GEN;
`else
    assign bus.core_step       = state_q == S_GEN;
`endif
    assign bus.out_capture     = state_q == S_GEN;
    assign bus.byte_idx        = state_q == S_GEN ? idx_q : '0;
    assign bus.output_is_ready = state_q == S_DONE;
    assign bus.busy            = state_q != S_IDLE;
endmodule

// File: tb/tb_cipher_sequencer.sv
// tb_cipher_sequencer: table-driven jobs with a byte_idx scoreboard plus abort/reset corner sequences.
module tb_cipher_sequencer;
    localparam int W = 4;
`ifdef CIPHER_SEQ_WARMUP_EN
    localparam int W_EFF = W;
`else
    localparam int W_EFF = 0;
`endif
    typedef struct {
        logic [3:0] len;
        int         caps;
        int         ack_delay;
        bit         hold;
    } vec_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   exp_q[$];
    vec_t tbl[6];

    cipher_sequencer_if bus();
    cipher_sequencer #(.WARMUP_CYCLES(W)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_ctrl"}, int'({bus.core_load, bus.core_step, bus.out_capture}), 0);
        check({tag, "_idx"}, int'(bus.byte_idx), 0);
        check({tag, "_ready"}, int'(bus.output_is_ready), 0);
    endtask

    task automatic run_job(input vec_t v);
        int cyc, loads, steps, want;
        bit rdy;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = v.len;
        for (int i = 0; i < v.caps; i++) exp_q.push_back(i);
        cyc = 0; loads = 0; steps = 0; rdy = 1'b0;
        while (!rdy && cyc < 300) begin
            @(negedge clk);
            if (!v.hold) bus.start = 1'b0;
            cyc++;
            loads += int'(bus.core_load);
            steps += int'(bus.core_step);
            if (bus.out_capture) begin
                want = exp_q.size() != 0 ? exp_q.pop_front() : -1;
                check("byte_idx", int'(bus.byte_idx), want);
            end
            rdy = bus.output_is_ready;
        end
        check("latency", cyc, W_EFF + v.caps + 2);
        check("load_cycles", loads, 1);
        check("step_cycles", steps, W_EFF + v.caps);
        check("missing_caps", exp_q.size(), 0);
        exp_q.delete();
        for (int i = 0; i < v.ack_delay; i++) begin
            @(negedge clk);
            check("ready_held", int'(bus.output_is_ready), 1);
            check("done_ctrl", int'({bus.core_load, bus.core_step, bus.out_capture}), 0);
        end
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        check("busy_after_ack", int'(bus.busy), 0);
        check("ready_after_ack", int'(bus.output_is_ready), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        tbl[0] = '{4'd3, 3, 0, 1'b0};
        tbl[1] = '{4'd0, 16, 0, 1'b0};
        tbl[2] = '{4'd1, 1, 2, 1'b0};
        tbl[3] = '{4'd15, 15, 0, 1'b0};
        tbl[4] = '{4'd3, 3, 5, 1'b1};
        tbl[5] = '{4'd2, 2, 0, 1'b0};
        bus.start = 1'b0; bus.abort = 1'b0; bus.ack = 1'b0; bus.len = '0;
        #12;
        check_quiet("reset");
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 6; k++) run_job(tbl[k]);

        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1; bus.ack = 1'b1;
        @(negedge clk);
        check_quiet("abort_vs_start");
        bus.start = 1'b0; bus.abort = 1'b0; bus.ack = 1'b0;

        bus.start = 1'b1; bus.len = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = bus.out_capture && bus.byte_idx == 4'd1;
        end
        check("abort_reached", int'(found), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_quiet("abort_gen");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ready", int'({bus.busy, bus.output_is_ready}), 0);
        end
        run_job('{4'd4, 4, 0, 1'b0});

        @(negedge clk);
        bus.start = 1'b1; bus.len = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_step", int'(bus.core_step), 1);
        #2 nrst = 1'b0;
        #1 check_quiet("async_reset");
        @(negedge clk);
        nrst = 1'b1;
        run_job('{4'd3, 3, 3, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
